// File: rtl/hpdcache_demux.sv
// Buffered valid/ready demultiplexer: one input channel fanned out to NOUTPUT
// output channels, each behind its own DEPTH-entry FIFO so a stalled consumer
// only blocks beats addressed to it.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   in_valid_i/in_ready_o input handshake
//   in_data_i            input payload
//   in_sel_i             destination (binary index, or one-hot when ONE_HOT_SEL)
//   out_valid_o/out_ready_i per-output handshake
//   out_data_o           per-output payload, output 0 in the LSBs
//   err_o                sticky: a beat with an illegal selector was consumed
module hpdcache_demux #(
    parameter int unsigned NOUTPUT     = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 2,
    parameter bit          ONE_HOT_SEL = 1'b0,
    parameter int unsigned SEL_WIDTH   = ONE_HOT_SEL ? NOUTPUT : $clog2(NOUTPUT)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    input  logic [SEL_WIDTH-1:0]            in_sel_i,
    output logic [NOUTPUT-1:0]              out_valid_o,
    input  logic [NOUTPUT-1:0]              out_ready_i,
    output logic [NOUTPUT*DATA_WIDTH-1:0]   out_data_o,
    output logic                            err_o
);

    // A 1-entry FIFO still needs a 1-bit pointer; it simply never leaves 0.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NOUTPUT-1:0] sel_vec;   // one-hot target, all-zero when illegal
    logic               sel_legal;
    logic [NOUTPUT-1:0] full;
    logic [NOUTPUT-1:0] push;
    logic [NOUTPUT-1:0] pop;
    logic               err_q;

    if (ONE_HOT_SEL) begin : g_onehot
        assign sel_legal = $onehot(in_sel_i);
        assign sel_vec   = sel_legal ? in_sel_i : '0;
    end else begin : g_binary
        // Out-of-range indices match no output, which is what makes them illegal.
        always_comb begin
            sel_vec = '0;
            for (int k = 0; k < NOUTPUT; k++) begin
                sel_vec[k] = (in_sel_i == SEL_WIDTH'(k));
            end
        end
        assign sel_legal = |sel_vec;
    end

    // Depends only on FIFO occupancy and the selector: no ready-to-ready path.
    // Illegal beats are always swallowed.
    assign in_ready_o = !sel_legal || ((sel_vec & full) == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (in_valid_i && !sel_legal) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    for (genvar k = 0; k < NOUTPUT; k++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      rptr_q;
        logic [PTR_W-1:0]      wptr_q;
        logic [CNT_W-1:0]      cnt_q;
        logic [PTR_W-1:0]      rptr_nxt;
        logic [PTR_W-1:0]      wptr_nxt;

        assign full[k]        = (cnt_q == CNT_W'(DEPTH));
        assign out_valid_o[k] = (cnt_q != '0);
        assign push[k]        = in_valid_i && in_ready_o && sel_vec[k];
        assign pop[k]         = out_valid_o[k] && out_ready_i[k];

        assign out_data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rptr_q];

        // Explicit wrap keeps non-trivial behaviour correct for DEPTH=1.
        assign rptr_nxt = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        assign wptr_nxt = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rptr_q <= '0;
                wptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[k]) begin
                    wptr_q <= wptr_nxt;
                end
                if (pop[k]) begin
                    rptr_q <= rptr_nxt;
                end
                if (push[k] && !pop[k]) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (!push[k] && pop[k]) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end

        // Payload storage needs no reset; stale entries are never presented.
        always_ff @(posedge clk_i) begin
            if (push[k]) begin
                mem_q[wptr_q] <= in_data_i;
            end
        end
    end

endmodule

// File: doc/hpdcache_demux.md
# hpdcache_demux

Buffered demultiplexer that routes one valid/ready input channel to one of NOUTPUT output channels. The destination is chosen by a per-beat selector, which is either binary or one-hot encoded. Each output has its own DEPTH-entry FIFO, so a stalled consumer does not block traffic to the other outputs. The block sits on the fan-out side of cache-internal request/response paths, where one producer feeds several independent consumers.

## Interface
- NOUTPUT, default 2: number of outputs, ≥2.
- DATA_WIDTH, default 32: width in bits of one data beat, ≥1.
- DEPTH, default 2: entries per output FIFO, ≥1, power of two.
- ONE_HOT_SEL, default 0: 1 means the selector is one-hot; 0 means it is binary.
- SEL_WIDTH (derived): NOUTPUT when ONE_HOT_SEL=1, otherwise $clog2(NOUTPUT).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when high together with in_valid_i.
- in_data_i  in  DATA_WIDTH  input payload.
- in_sel_i  in  SEL_WIDTH  destination output index.
- out_valid_o  out  NOUTPUT  per-output valid.
- out_ready_i  in  NOUTPUT  per-output ready.
- out_data_o  out  NOUTPUT×DATA_WIDTH  per-output payload, packed, index 0 in the LSBs.
- err_o  out  1  sticky flag: an illegal selector was consumed.

## Operation
- Selector legality:
  - Binary mode: legal iff in_sel_i < NOUTPUT.
  - One-hot mode: legal iff exactly one bit is set. Zero bits or multiple bits are illegal.
- Target index t: decoded from in_sel_i when the selector is legal.
- in_ready_o:
  - Legal selector: in_ready_o = !full[t].
  - Illegal selector: in_ready_o = 1.
  - in_ready_o depends only on registered state and in_sel_i. It never depends on out_ready_i, so there is no ready-to-ready combinational path.
- Push: in_valid_i && in_ready_o && legal selector → write in_data_i into FIFO t.
- Illegal beat: in_valid_i && illegal selector → the beat is consumed and dropped, and err_o is set. err_o stays 1 until reset.
- Pop: out_valid_o[k] && out_ready_i[k] → FIFO k advances its read pointer.
- Ordering: per-output order equals acceptance order. There is no ordering guarantee across different outputs.
- Each FIFO holds:
  - read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - an occupancy counter of $clog2(DEPTH+1) bits.
  - empty = (cnt==0); full = (cnt==DEPTH).
- Simultaneous push and pop on the same FIFO:
  - Not full: both happen and cnt is unchanged.
  - Full: the pop happens and the push is refused, because in_ready_o was 0. A beat held at in_valid_i (already valid, waiting for ready) is accepted in the next cycle.
- out_valid_o[k] = !empty[k]; out_data_o[k] = head entry of FIFO k.
- When out_valid_o[k]=0, out_data_o[k] is don't-care.
- Pops on different outputs are independent and may all occur in the same cycle.

## Timing
- Reset (rst_ni=0 at a clock edge):
  - All pointers and counters clear to 0, and err_o clears to 0.
  - out_valid_o = 0 for all outputs from the cycle after the edge.
- Reset mid-operation: buffered beats are discarded without being presented.
- After reset with a legal selector, in_ready_o=1.
- Latency: a beat accepted at edge n is visible on out_valid_o/out_data_o after edge n, meaning one cycle. There is no combinational input-to-output path.
- Throughput:
  - One beat per cycle into any non-full output.
  - A single output with DEPTH=1 sustains one beat every 2 cycles (full blocks push in the pop cycle). DEPTH≥2 sustains one beat per cycle.
- Output stability: while out_valid_o[k]=1 && out_ready_i[k]=0, out_data_o[k] holds its value.
- Input protocol: the producer keeps in_data_i and in_sel_i stable while in_valid_i=1 && in_ready_o=0.
- err_o asserts in the cycle after the illegal beat is consumed.

## Test plan
- Post-reset idle, binary mode, NOUTPUT=4, DEPTH=2 → all out_valid_o=0, err_o=0, in_ready_o=1.
- Routing: push 0xA0..0xA3 with sel 0,1,2,3, all out_ready_i=1 → each output k shows 0xA0+k exactly one cycle after its acceptance, with a single valid cycle.
- Backpressure: out_ready_i[1]=0; push 0x11, 0x22, 0x33 to output 1 → third beat sees in_ready_o=0. Beats to output 2 are still accepted. Raising out_ready_i[1] drains 0x11, 0x22, then 0x33 in order.
- Full with simultaneous pop: FIFO 0 full, out_ready_i[0]=1, new beat held at in_valid_i for output 0 → pop occurs and the push is refused. The beat is accepted next cycle, and cnt returns to DEPTH.
- Illegal selector:
  - Binary mode, NOUTPUT=3, sel=3 → in_ready_o=1, no output valid, err_o=1 from the next cycle and staying 1.
  - One-hot mode, sel=4'b0110 → same response.
- Reset mid-stream: FIFOs partly filled and err_o=1, rst_ni=0 for one cycle → all outputs invalid, err_o=0. The first beat after reset appears alone on its output.
